// File: rtl/sha2_pkg.sv
// Shared SHA-2 message-schedule definitions: schedule FSM states, round counts
// and the small-sigma rotate/shift amounts for 32- and 64-bit word widths.
package sha2_pkg;

  typedef enum logic {
    LOAD   = 1'b0,
    EXPAND = 1'b1
  } sched_state_t;

  localparam int unsigned S0_ROT_A_32 = 7;
  localparam int unsigned S0_ROT_B_32 = 18;
  localparam int unsigned S0_SHR_32   = 3;
  localparam int unsigned S1_ROT_A_32 = 17;
  localparam int unsigned S1_ROT_B_32 = 19;
  localparam int unsigned S1_SHR_32   = 10;

  localparam int unsigned S0_ROT_A_64 = 1;
  localparam int unsigned S0_ROT_B_64 = 8;
  localparam int unsigned S0_SHR_64   = 7;
  localparam int unsigned S1_ROT_A_64 = 19;
  localparam int unsigned S1_ROT_B_64 = 61;
  localparam int unsigned S1_SHR_64   = 6;

  // Zero marks an unsupported width so instantiating modules can reject it.
  function automatic int unsigned rounds_for(input int unsigned word_w);
    if (word_w == 32) return 64;
    if (word_w == 64) return 80;
    return 0;
  endfunction

  // which: 0 = first rotate, 1 = second rotate, 2 = logical shift.
  function automatic int unsigned sigma_shift(input int unsigned word_w,
                                              input int unsigned sel,
                                              input int unsigned which);
    if (word_w == 64) begin
      if (sel == 0) return (which == 0) ? S0_ROT_A_64 : (which == 1) ? S0_ROT_B_64 : S0_SHR_64;
      return (which == 0) ? S1_ROT_A_64 : (which == 1) ? S1_ROT_B_64 : S1_SHR_64;
    end
    if (sel == 0) return (which == 0) ? S0_ROT_A_32 : (which == 1) ? S0_ROT_B_32 : S0_SHR_32;
    return (which == 0) ? S1_ROT_A_32 : (which == 1) ? S1_ROT_B_32 : S1_SHR_32;
  endfunction

endpackage

// File: rtl/sha2_small_sigma.sv
// SHA-2 small sigma function: SEL=0 gives sigma0, SEL=1 gives sigma1.
module sha2_small_sigma
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned SEL    = 0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  localparam int unsigned ROT_A = sigma_shift(WORD_W, SEL, 0);
  localparam int unsigned ROT_B = sigma_shift(WORD_W, SEL, 1);
  localparam int unsigned SHR   = sigma_shift(WORD_W, SEL, 2);

  always_comb begin
    y = ((x >> ROT_A) | (x << (WORD_W - ROT_A)))
      ^ ((x >> ROT_B) | (x << (WORD_W - ROT_B)))
      ^ (x >> SHR);
  end

endmodule

// File: rtl/msg_schedule.sv
// SHA-2 message schedule: streams in 16 block words, then expands them to the
// full ROUNDS-word schedule, one word per cycle through a ready/valid output.
module msg_schedule
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [6:0]        out_idx,
  output logic              out_last
);

  localparam int unsigned ROUNDS = rounds_for(WORD_W);

  if (ROUNDS == 0) begin : g_bad_width
    $error("msg_schedule: WORD_W must be 32 or 64");
  end

  localparam logic [6:0] LAST_T      = 7'(ROUNDS - 1);
  localparam logic [6:0] LAST_LOAD_T = 7'd15;

  sched_state_t      state, state_nx;
  logic [6:0]        t;
  logic [WORD_W-1:0] win [16];
  logic              out_free;
  logic              load;
  logic [WORD_W-1:0] new_word;
  logic [WORD_W-1:0] sig0_w, sig1_w, expand_w;

  // win[15] holds W[t-1], win[0] holds W[t-16].
  sha2_small_sigma #(.WORD_W(WORD_W), .SEL(0)) u_sig0 (
    .x (win[1]),
    .y (sig0_w)
  );

  sha2_small_sigma #(.WORD_W(WORD_W), .SEL(1)) u_sig1 (
    .x (win[14]),
    .y (sig1_w)
  );

  assign expand_w = sig1_w + win[9] + sig0_w + win[0];
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    load     = 1'b0;
    new_word = in_word;
    case (state)
      LOAD: begin
        in_ready = out_free && rst_n;
        load     = in_valid && in_ready;
        if (load && t == LAST_LOAD_T) state_nx = EXPAND;
      end
      EXPAND: begin
        load     = out_free;
        new_word = expand_w;
        if (load && t == LAST_T) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  // Window and output register advance together, so a stalled output freezes both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t         <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15]   <= new_word;
      out_word  <= new_word;
      out_idx   <= t;
      out_last  <= (t == LAST_T);
      out_valid <= 1'b1;
      t         <= (t == LAST_T) ? '0 : t + 7'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/msg_schedule.md
MSG_SCHEDULE -- requirements
Module: msg_schedule

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning SHA-2 word width; legal values 32 (SHA-224/256) and 64 (SHA-384/512).
REQ-002 SHALL derive localparam ROUNDS from WORD_W: 64 when WORD_W=32, 80 when WORD_W=64.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  in_word carries a message-block word.
REQ-006 in_ready  output  1  block accepts in_word this cycle.
REQ-007 in_word  input  WORD_W  block word, W0 first, big-endian word order.
REQ-008 out_valid  output  1  out_word/out_idx/out_last valid.
REQ-009 out_ready  input  1  downstream consumes the output this cycle.
REQ-010 out_word  output  WORD_W  schedule word W[out_idx].
REQ-011 out_idx  output  7  round index t, 0..ROUNDS-1.
REQ-012 out_last  output  1  high with the word whose out_idx=ROUNDS-1.

Function
REQ-013 Input transfer SHALL occur when in_valid and in_ready are high; output transfer when out_valid and out_ready are high.
REQ-014 FSM states SHALL be LOAD and EXPAND; reset state LOAD.
REQ-015 Output register SHALL be free when out_valid=0 or an output transfer occurs in that cycle.
REQ-016 In LOAD, in_ready SHALL equal output-register-free; in EXPAND, in_ready SHALL be 0.
REQ-017 Each accepted input word SHALL be shifted into a 16-entry window and loaded into the output register with idx=t, out_valid=1 on the next cycle (latency 1).
REQ-018 On the 16th accepted word (t=15), FSM SHALL move to EXPAND.
REQ-019 In EXPAND, whenever the output register is free, W[t] = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16] modulo 2^WORD_W SHALL be computed, shifted into the window and loaded into the output register.
REQ-020 WORD_W=32: sig0 = ROTR7^ROTR18^SHR3; sig1 = ROTR17^ROTR19^SHR10.
REQ-021 WORD_W=64: sig0 = ROTR1^ROTR8^SHR7; sig1 = ROTR19^ROTR61^SHR6.
REQ-022 When W[ROUNDS-1] is loaded, FSM SHALL return to LOAD and t SHALL wrap to 0; the next block's W0 may be accepted in the same cycle that W[ROUNDS-1] is consumed.
REQ-023 While out_valid=1 and out_ready=0, out_word, out_idx, out_last SHALL hold stable and the window SHALL not advance.
REQ-024 Throughput SHALL be one word per cycle when in_valid and out_ready are held high (ROUNDS cycles per block, no bubbles between blocks).
REQ-025 Illegal WORD_W SHALL cause an elaboration-time error.

Reset
REQ-026 On rst_n=0 at a clock edge: state=LOAD, t=0, window cleared to 0, out_valid=0, out_word=0, out_idx=0, out_last=0; in_ready SHALL be 0 during reset.
REQ-027 Reset mid-block SHALL discard the partial block; the first accepted word after reset SHALL be treated as W0.

Structure
REQ-028 Shared package sha2_pkg SHALL hold the rotation/shift constants per width, the ROUNDS mapping function and the FSM state enum.
REQ-029 Sigma functions SHALL live in one combinational sub-module sha2_small_sigma (parameters WORD_W, SEL = 0/1 for sig0/sig1), instantiated twice.

Verification
REQ-030 WORD_W=32, "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018) streamed, out_ready=1 -> W16=0x61626380, W17=0x000F0000, all 64 words match a golden model, out_last only at idx 63.
REQ-031 WORD_W=64, "abc" block (W0=0x6162638000000000, W15=0x18) -> W17=0x00030000000000C0, 80 words match model, out_last at idx 79.
REQ-032 Random out_ready backpressure (50%) over 3 back-to-back blocks -> output sequence identical to the no-stall run; outputs stable while stalled.
REQ-033 in_valid held high across a block boundary -> next block's W0 accepted in the cycle W63 is consumed; zero idle cycles between blocks.
REQ-034 rst_n pulsed low after 9 input words -> out_valid=0 next cycle; new full block then produces correct schedule from idx 0.
REQ-035 in_valid asserted during EXPAND -> in_ready=0, no word consumed, schedule unaffected.
